// File: rtl/intr_ctrl.sv
// External interrupt controller: synchronises NIRQ lines, applies polarity/edge/mask, drives a level request.
// Latency: raw line to PEND in SYNC_STAGES+1 edges, to o_intr one edge later; register reads return next cycle.
// Backpressure: none; o_intr holds while any unmasked line is pending, with no handshake.
module intr_ctrl #(
    parameter int NIRQ        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [NIRQ-1:0] i_irq,
    input  logic [2:0]      i_reg_addr,
    input  logic            i_reg_wr,
    input  logic            i_reg_rd,
    input  logic [31:0]     i_reg_wdata,
    output logic [31:0]     o_reg_rdata,
    output logic            o_intr,
    output logic [4:0]      o_irq_id
);

    localparam logic [2:0] A_PEND = 3'd0;
    localparam logic [2:0] A_MASK = 3'd1;
    localparam logic [2:0] A_EDGE = 3'd2;
    localparam logic [2:0] A_POL  = 3'd3;
    localparam logic [2:0] A_ID   = 3'd4;
    localparam logic [2:0] A_RAW  = 3'd5;

    logic [SYNC_STAGES-1:0][NIRQ-1:0] sync_q;
    logic [NIRQ-1:0] prev_q, pend_q, mask_q, edge_q, pol_q;
    logic [NIRQ-1:0] lvl, rise, w1c, pend_nxt, pm, wdat;
    logic [4:0]      irq_id;
    logic [31:0]     rd_val;
    logic            unused_wdata;

    assign unused_wdata = ^i_reg_wdata;
    assign wdat         = i_reg_wdata[NIRQ-1:0];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= i_irq;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // prev follows lvl every cycle, so mode switches never fabricate an edge,
    // while a POL write that flips lvl high does register as one.
    assign lvl      = sync_q[SYNC_STAGES-1] ^ pol_q;
    assign rise     = lvl & ~prev_q;
    assign w1c      = (i_reg_wr && i_reg_addr == A_PEND) ? wdat : '0;
    assign pend_nxt = (edge_q & (rise | (pend_q & ~w1c))) | (~edge_q & lvl);
    assign pm       = pend_q & mask_q;

    always_comb begin
        irq_id = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (pm[i]) irq_id = 5'(i);
        end
    end

    always_comb begin
        rd_val = '0;
        case (i_reg_addr)
            A_PEND:  rd_val[NIRQ-1:0] = pend_q;
            A_MASK:  rd_val[NIRQ-1:0] = mask_q;
            A_EDGE:  rd_val[NIRQ-1:0] = edge_q;
            A_POL:   rd_val[NIRQ-1:0] = pol_q;
            A_ID:    rd_val = {|pm, 26'b0, irq_id};
            A_RAW:   rd_val[NIRQ-1:0] = lvl;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_q      <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            edge_q      <= '0;
            pol_q       <= '0;
            o_intr      <= 1'b0;
            o_irq_id    <= '0;
            o_reg_rdata <= '0;
        end else begin
            prev_q   <= lvl;
            pend_q   <= pend_nxt;
            o_intr   <= |pm;
            o_irq_id <= irq_id;
            if (i_reg_rd) o_reg_rdata <= rd_val;
            if (i_reg_wr) begin
                case (i_reg_addr)
                    A_MASK:  mask_q <= wdat;
                    A_EDGE:  edge_q <= wdat;
                    A_POL:   pol_q  <= wdat;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with hand-computed expectations (NIRQ=8, SYNC_STAGES=2).
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  i_irq = '0;
    logic [2:0]  i_reg_addr = '0;
    logic        i_reg_wr = 1'b0;
    logic        i_reg_rd = 1'b0;
    logic [31:0] i_reg_wdata = '0;
    logic [31:0] o_reg_rdata;
    logic        o_intr;
    logic [4:0]  o_irq_id;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] rd;

    intr_ctrl #(.NIRQ(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .i_irq      (i_irq),
        .i_reg_addr (i_reg_addr),
        .i_reg_wr   (i_reg_wr),
        .i_reg_rd   (i_reg_rd),
        .i_reg_wdata(i_reg_wdata),
        .o_reg_rdata(o_reg_rdata),
        .o_intr     (o_intr),
        .o_irq_id   (o_irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // All bus tasks are entered at a negedge and return at the following negedge.
    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        i_reg_addr = a; i_reg_wdata = d; i_reg_wr = 1'b1;
        @(negedge clk);
        i_reg_wr = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        i_reg_addr = a; i_reg_rd = 1'b1;
        @(negedge clk);
        i_reg_rd = 1'b0;
        d = o_reg_rdata;
    endtask

    task automatic reg_wr_rd(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] d);
        i_reg_addr = a; i_reg_wdata = wd; i_reg_wr = 1'b1; i_reg_rd = 1'b1;
        @(negedge clk);
        i_reg_wr = 1'b0; i_reg_rd = 1'b0;
        d = o_reg_rdata;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] irq);
        i_irq = irq;
        nrst  = 1'b0;
        wait_cyc(2);
        nrst  = 1'b1;
    endtask

    initial begin
        // Reset with all lines high: everything reads zero right after release.
        @(negedge clk);
        do_reset(8'hFF);
        chk("rst_intr", {31'b0, o_intr}, 32'h0);
        chk("rst_id_port", {27'b0, o_irq_id}, 32'h0);
        chk("rst_rdata", o_reg_rdata, 32'h0);
        reg_read(3'd0, rd); chk("rst_pend", rd, 32'h0);
        reg_read(3'd1, rd); chk("rst_mask", rd, 32'h0);
        reg_read(3'd2, rd); chk("rst_edge", rd, 32'h0);
        reg_read(3'd3, rd); chk("rst_pol", rd, 32'h0);
        reg_read(3'd4, rd); chk("rst_idreg", rd, 32'h0);

        // Level line 3: o_intr rises on the 4th edge after the input changes, falls likewise.
        do_reset(8'h00);
        reg_write(3'd1, 32'h08);
        i_irq = 8'h08;
        wait_cyc(3); chk("lvl_rise_e3", {31'b0, o_intr}, 32'h0);
        wait_cyc(1); chk("lvl_rise_e4", {31'b0, o_intr}, 32'h1);
        chk("lvl_id_port", {27'b0, o_irq_id}, 32'd3);
        reg_read(3'd4, rd); chk("lvl_idreg", rd, 32'h80000003);
        i_irq = 8'h00;
        wait_cyc(3); chk("lvl_fall_e3", {31'b0, o_intr}, 32'h1);
        wait_cyc(1); chk("lvl_fall_e4", {31'b0, o_intr}, 32'h0);

        // Edge line 5: a 1-cycle pulse is latched, W1C clears it.
        do_reset(8'h00);
        reg_write(3'd2, 32'h20);
        reg_write(3'd1, 32'h20);
        i_irq = 8'h20;
        wait_cyc(1);
        i_irq = 8'h00;
        wait_cyc(6);
        reg_read(3'd0, rd); chk("edge_pend_held", rd, 32'h20);
        chk("edge_intr_held", {31'b0, o_intr}, 32'h1);
        reg_write(3'd0, 32'h20);
        chk("w1c_intr_lag", {31'b0, o_intr}, 32'h1);
        wait_cyc(1); chk("w1c_intr_low", {31'b0, o_intr}, 32'h0);
        reg_read(3'd0, rd); chk("w1c_pend", rd, 32'h0);

        // Set PEND[5], then a new rise lands in the same cycle as W1C: set wins.
        i_irq = 8'h20; wait_cyc(1); i_irq = 8'h00;
        wait_cyc(6);
        chk("coin_pre_intr", {31'b0, o_intr}, 32'h1);
        i_irq = 8'h20; wait_cyc(1);
        i_irq = 8'h00; wait_cyc(1);
        reg_write(3'd0, 32'h20);
        reg_read(3'd0, rd); chk("coin_pend", rd, 32'h20);
        wait_cyc(2); chk("coin_intr", {31'b0, o_intr}, 32'h1);

        // Mid-operation reset clears o_intr immediately.
        nrst = 1'b0; #1;
        chk("midrst_intr", {31'b0, o_intr}, 32'h0);
        wait_cyc(1); nrst = 1'b1;

        // Fixed priority: lowest index wins.
        do_reset(8'h00);
        reg_write(3'd1, 32'hFF);
        i_irq = 8'h42;
        wait_cyc(5);
        reg_read(3'd4, rd); chk("prio_16", rd, 32'h80000001);
        chk("prio_port_16", {27'b0, o_irq_id}, 32'd1);
        i_irq = 8'h40;
        wait_cyc(5);
        reg_read(3'd4, rd); chk("prio_6", rd, 32'h80000006);
        reg_read(3'd5, rd); chk("prio_raw", rd, 32'h40);
        reg_read(3'd0, rd); chk("prio_pend", rd, 32'h40);

        // Polarity inversion with line low; mask enables it one edge after the write.
        do_reset(8'h00);
        reg_write(3'd3, 32'h04);
        wait_cyc(3);
        reg_read(3'd0, rd); chk("pol_pend", rd, 32'h04);
        reg_read(3'd5, rd); chk("pol_raw", rd, 32'h04);
        chk("pol_intr_masked", {31'b0, o_intr}, 32'h0);
        reg_write(3'd1, 32'h04);
        chk("pol_mask_lag", {31'b0, o_intr}, 32'h0);
        wait_cyc(1); chk("pol_intr", {31'b0, o_intr}, 32'h1);

        // Simultaneous write/read returns the old value; high bits and unmapped index read 0.
        reg_wr_rd(3'd1, 32'h0F, rd); chk("wr_rd_old", rd, 32'h04);
        reg_read(3'd1, rd); chk("wr_rd_new", rd, 32'h0F);
        reg_write(3'd1, 32'hFFFF_FFFF);
        reg_read(3'd1, rd); chk("mask_hibits", rd, 32'hFF);
        reg_read(3'd6, rd); chk("unmapped", rd, 32'h0);
        wait_cyc(2); chk("rdata_hold", o_reg_rdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
